// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//   Mode-0 SPI slave that answers an SPI master. Every frame shifts a preloaded
//   N-bit word out on MISO (MSB first) while capturing N MOSI bits into dataO.
//   The serial pins are oversampled in the Clock domain, so SCLK must be slow
//   relative to Clock (each phase at least 4 Clock cycles).
//
// Ports
//   Clock    system clock
//   Reset    asynchronous, active-low reset
//   data     word to transmit in the next frame
//   load     1-cycle strobe, captures data into the transmit buffer
//   busy     high while a frame is in progress
//   arrived  1-cycle pulse, N bits received and dataO updated
//   aborted  1-cycle pulse, CS released before N bits were received
//   dataO    last complete received word
//   SCLK     serial clock from the master, idle low
//   MOSI     master-to-slave data
//   MISO     slave-to-master data, 0 when not shifting
//   CS       chip select, active low
// -----------------------------------------------------------------------------
module spi_slave_responder #(
  parameter int N    = 15,
  parameter int CNTW = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] data,
  input  logic         load,
  output logic         busy,
  output logic         arrived,
  output logic         aborted,
  output logic [N-1:0] dataO,
  input  logic         SCLK,
  input  logic         MOSI,
  output logic         MISO,
  input  logic         CS
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t          state;
  logic [N-1:0]    tx_buf;
  logic [N-2:0]    shreg;   // bits still to send; the MSB is already on MISO
  logic [N-2:0]    rxreg;   // bits received so far in this frame
  logic [CNTW-1:0] bitcnt;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  // Two synchroniser flops per pin, plus a third on SCLK/CS for edge detection.
  // NOTE: synchroniser flops reset to the idle pin levels (SCLK low, CS high)
  // so that leaving reset never fabricates an edge on an idle bus.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= CS;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_fall   = ~cs_s2 & cs_d;
  assign cs_rise   = cs_s2 & ~cs_d;

  // A load coinciding with the CS fall must win over the older buffer contents.
  logic [N-1:0] tx_sel;
  assign tx_sel = load ? data : tx_buf;

  logic [N-1:0] rx_next;
  assign rx_next = {rxreg, mosi_s2};

  assign busy = (state != S_IDLE);

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; the pulse outputs default low each cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      tx_buf  <= '0;
      shreg   <= '0;
      rxreg   <= '0;
      bitcnt  <= '0;
      dataO   <= '0;
      MISO    <= 1'b0;
      arrived <= 1'b0;
      aborted <= 1'b0;
    end else begin
      arrived <= 1'b0;
      aborted <= 1'b0;
      if (load) tx_buf <= data;

      case (state)
        S_IDLE: begin
          MISO <= 1'b0;
          if (cs_fall) begin
            shreg  <= tx_sel[N-2:0];
            MISO   <= tx_sel[N-1];
            bitcnt <= '0;
            state  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // CS release takes priority over any SCLK edge in the same cycle.
          if (cs_rise) begin
            aborted <= 1'b1;
            MISO    <= 1'b0;
            state   <= S_IDLE;
          end else if (sclk_rise) begin
            rxreg  <= rx_next[N-2:0];
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == CNTW'(N - 1)) begin
              dataO   <= rx_next;
              arrived <= 1'b1;
              MISO    <= 1'b0;
              state   <= S_WAIT;
            end
          end else if (sclk_fall) begin
            MISO  <= shreg[N-2];
            shreg <= shreg << 1;
          end
        end

        S_WAIT: begin
          // Surplus SCLK edges are ignored until the master releases CS.
          MISO <= 1'b0;
          if (cs_rise) state <= S_IDLE;
        end

        default: begin
          MISO  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//   Bit-bangs a mode-0 SPI master against spi_slave_responder. Frames come from
//   a table of stimulus/expectation records; received words are scored through
//   a queue filled when each frame starts and drained on every arrived pulse.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

  localparam int N    = 15;
  localparam int HALF = 8;   // Clock cycles per SCLK phase

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [N-1:0] data  = '0;
  logic         load  = 1'b0;
  logic         busy, arrived, aborted, MISO;
  logic [N-1:0] dataO;
  logic         SCLK  = 1'b0;
  logic         MOSI  = 1'b0;
  logic         CS    = 1'b1;

  spi_slave_responder #(.N(N), .CNTW(4)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .data   (data),
    .load   (load),
    .busy   (busy),
    .arrived(arrived),
    .aborted(aborted),
    .dataO  (dataO),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .CS     (CS)
  );

  always #5 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;
  int arr_cnt = 0;
  int abt_cnt = 0;
  logic [N-1:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Pulse monitor and scoreboard drain.
  always @(negedge Clock) begin
    if (arrived || aborted) check("pulse_exclusive", {31'b0, arrived & aborted}, 32'd0);
    if (aborted) abt_cnt++;
    if (arrived) begin
      arr_cnt++;
      if (sb_q.size() == 0) check("unexpected_arrived", 32'd1, 32'd0);
      else check("arrived_dataO", {17'b0, dataO}, {17'b0, sb_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit           pre_load;
    logic [N-1:0] pre_word;
    bit           fall_load;
    logic [N-1:0] fall_word;
    bit           mid_load;
    logic [N-1:0] mid_word;
    logic [N-1:0] mosi_word;
    int           nclk;
    logic [N-1:0] exp_tx;
    bit           exp_arrived;
    bit           exp_aborted;
    logic [N-1:0] exp_dataO;
  } vec_t;

  function automatic vec_t mk(input bit pl, input logic [N-1:0] pw, input bit fl,
                              input logic [N-1:0] fw, input bit ml, input logic [N-1:0] mw,
                              input logic [N-1:0] mosi, input int nclk, input logic [N-1:0] tx,
                              input bit ea, input bit eb, input logic [N-1:0] ed);
    vec_t v;
    v.pre_load = pl;  v.pre_word = pw;
    v.fall_load = fl; v.fall_word = fw;
    v.mid_load = ml;  v.mid_word = mw;
    v.mosi_word = mosi; v.nclk = nclk;
    v.exp_tx = tx; v.exp_arrived = ea; v.exp_aborted = eb; v.exp_dataO = ed;
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    int          a0, b0;
    logic [31:0] mrx, ext;
    a0  = arr_cnt;
    b0  = abt_cnt;
    mrx = '0;
    check("busy_before", {31'b0, busy}, 32'd0);
    if (v.pre_load) begin
      data = v.pre_word; load = 1'b1;
      wait_cyc(1);
      load = 1'b0;
      wait_cyc(2);
    end
    if (v.exp_arrived) sb_q.push_back(v.exp_dataO);
    CS = 1'b0;
    if (v.fall_load) begin
      // The synced CS fall is seen in the third cycle after the pin drop.
      wait_cyc(2);
      data = v.fall_word; load = 1'b1;
      wait_cyc(1);
      load = 1'b0;
      wait_cyc(HALF - 3);
    end else begin
      wait_cyc(HALF);
    end
    for (int i = 0; i < v.nclk; i++) begin
      MOSI = (i < N) ? v.mosi_word[N-1-i] : 1'b0;
      wait_cyc(HALF);
      mrx  = {mrx[30:0], MISO};
      SCLK = 1'b1;
      wait_cyc(HALF);
      SCLK = 1'b0;
      if (i == 2) check("busy_mid", {31'b0, busy}, 32'd1);
      if (v.mid_load && i == 4) begin
        data = v.mid_word; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
      end
    end
    wait_cyc(HALF);
    CS   = 1'b1;
    MOSI = 1'b0;
    wait_cyc(2 * HALF);
    // Bits past the N-th read as 0, so the expected stream is tx followed by zeros.
    ext = {15'b0, v.exp_tx, 2'b00};
    check("master_rx", mrx, ext >> (17 - v.nclk));
    check("arrived_count", arr_cnt - a0, {31'b0, v.exp_arrived});
    check("aborted_count", abt_cnt - b0, {31'b0, v.exp_aborted});
    check("dataO_after", {17'b0, dataO}, {17'b0, v.exp_dataO});
    check("busy_after", {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int a0, b0;
    //            pre        fall       mid        mosi      nclk tx       arr abt dataO
    vecs[0] = mk(1, 15'h0528, 0, 15'h0, 0, 15'h0, 15'h5A5A, 15, 15'h0528, 1, 0, 15'h5A5A);
    vecs[1] = mk(1, 15'h7FFF, 0, 15'h0, 0, 15'h0, 15'h1357, 15, 15'h7FFF, 1, 0, 15'h1357);
    vecs[2] = mk(1, 15'h0001, 0, 15'h0, 0, 15'h0, 15'h2468, 15, 15'h0001, 1, 0, 15'h2468);
    vecs[3] = mk(1, 15'h2AAA, 0, 15'h0, 0, 15'h0, 15'h7777,  7, 15'h2AAA, 0, 1, 15'h2468);
    vecs[4] = mk(1, 15'h0BAD, 1, 15'h1234, 0, 15'h0, 15'h0C0C, 15, 15'h1234, 1, 0, 15'h0C0C);
    vecs[5] = mk(0, 15'h0, 0, 15'h0, 1, 15'h4321, 15'h3003, 15, 15'h1234, 1, 0, 15'h3003);
    vecs[6] = mk(0, 15'h0, 0, 15'h0, 0, 15'h0, 15'h5555, 15, 15'h4321, 1, 0, 15'h5555);
    vecs[7] = mk(1, 15'h6B1D, 0, 15'h0, 0, 15'h0, 15'h0F0F, 17, 15'h6B1D, 1, 0, 15'h0F0F);
    vecs[8] = mk(1, 15'h7E01, 0, 15'h0, 0, 15'h0, 15'h1111, 14, 15'h7E01, 0, 1, 15'h0F0F);

    // Reset state.
    wait_cyc(3);
    check("rst_busy",    {31'b0, busy},    32'd0);
    check("rst_arrived", {31'b0, arrived}, 32'd0);
    check("rst_aborted", {31'b0, aborted}, 32'd0);
    check("rst_miso",    {31'b0, MISO},    32'd0);
    check("rst_dataO",   {17'b0, dataO},   32'd0);
    Reset = 1'b1;
    wait_cyc(4);

    foreach (vecs[k]) run_frame(vecs[k]);

    // Reset in the middle of a frame.
    data = 15'h7FFF; load = 1'b1;
    wait_cyc(1);
    load = 1'b0;
    CS   = 1'b0;
    MOSI = 1'b1;
    wait_cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b1; wait_cyc(HALF);
      SCLK = 1'b0; wait_cyc(HALF);
    end
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_miso", {31'b0, MISO}, 32'd1);
    a0 = arr_cnt;
    b0 = abt_cnt;
    Reset = 1'b0;
    wait_cyc(1);
    check("midrst_busy",  {31'b0, busy},  32'd0);
    check("midrst_miso",  {31'b0, MISO},  32'd0);
    check("midrst_dataO", {17'b0, dataO}, 32'd0);
    CS = 1'b1;
    SCLK = 1'b1; wait_cyc(HALF);
    SCLK = 1'b0; wait_cyc(HALF);
    Reset = 1'b1;
    MOSI  = 1'b0;
    wait_cyc(2 * HALF);
    check("postrst_arrived", arr_cnt - a0, 32'd0);
    check("postrst_aborted", abt_cnt - b0, 32'd0);
    check("postrst_busy", {31'b0, busy}, 32'd0);

    // After reset the transmit buffer is empty, so an unloaded frame sends zero.
    run_frame(mk(0, 15'h0, 0, 15'h0, 0, 15'h0, 15'h2C3D, 15, 15'h0000, 1, 0, 15'h2C3D));

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
